// File: rtl/sfp_pkg.sv
// Shared types and constants for the psum read-modify-write accumulation stage.
package sfp_pkg;

    localparam int unsigned COL      = 8;
    localparam int unsigned PSUM_BW  = 20;
    localparam int unsigned SRAM_BIT = COL * PSUM_BW;
    localparam int unsigned ADDR_W   = 4;

    // Signed lane saturation limits for the default lane width
    localparam logic [PSUM_BW-1:0] LANE_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic [PSUM_BW-1:0] LANE_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

endpackage

// File: rtl/sfp_accum_if.sv
// Upstream psum-vector handshake into the accumulation stage.
interface sfp_accum_if
    import sfp_pkg::*;
#(
    parameter int unsigned sram_bit = SRAM_BIT
) ();
    logic                in_valid;
    logic                in_ready;
    logic [sram_bit-1:0] in_data;
    logic [ADDR_W-1:0]   in_addr;
    logic                acc_mode;
    logic                relu_en;

    modport master (output in_valid, in_data, in_addr, acc_mode, relu_en, input in_ready);
    modport slave  (input in_valid, in_data, in_addr, acc_mode, relu_en, output in_ready);
endinterface

// File: rtl/sfp_lane.sv
// One lane: optional add of the stored value, signed saturation, optional ReLU.
// ReLU is compiled in only when SFP_RELU_EN is defined.
module sfp_lane
    import sfp_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW
) (
    input  logic               acc,
    input  logic               relu_en,
    input  logic [psum_bw-1:0] a,
    input  logic [psum_bw-1:0] q,
    output logic [psum_bw-1:0] y
);
    localparam logic [psum_bw-1:0] SAT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] SAT_MIN = {1'b1, {(psum_bw-1){1'b0}}};

    logic [psum_bw:0]   sum;
    logic [psum_bw-1:0] sat;

    // Overflow shows as disagreement between the two top bits of the wide sum
    always_comb begin
        sum = {a[psum_bw-1], a};
        if (acc) begin
            sum = {q[psum_bw-1], q} + {a[psum_bw-1], a};
        end
        sat = sum[psum_bw-1:0];
        if (sum[psum_bw] != sum[psum_bw-1]) begin
            sat = sum[psum_bw] ? SAT_MIN : SAT_MAX;
        end
    end

`ifdef SFP_RELU_EN
    assign y = (relu_en && sat[psum_bw-1]) ? '0 : sat;
`else
    logic unused_relu;
    assign unused_relu = relu_en;
    assign y = sat;
`endif

endmodule

// File: rtl/sfp_accum.sv
// Read-modify-write stage in front of the 16-entry psum SRAM: overwrite or
// saturating accumulate per vector. Optional ReLU via SFP_RELU_EN.
module sfp_accum
    import sfp_pkg::*;
#(
    parameter int unsigned col     = COL,
    parameter int unsigned psum_bw = PSUM_BW,
    localparam int unsigned sram_bit = col * psum_bw
) (
    input  logic                clk,
    input  logic                reset_n,
    sfp_accum_if.slave          in_if,
    input  logic [sram_bit-1:0] sram_q,
    output logic                sram_cen,
    output logic                sram_wen,
    output logic [ADDR_W-1:0]   sram_a,
    output logic [sram_bit-1:0] sram_d,
    output logic                wr_done
);
    state_e              state;
    state_e              state_nxt;
    logic [sram_bit-1:0] data_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                acc_q;
    logic                relu_q;
    logic [sram_bit-1:0] result;
    logic                accept;

    assign accept = in_if.in_valid && in_if.in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = in_if.acc_mode ? ST_RD : ST_WR;
            ST_RD:   state_nxt = ST_WR;
            ST_WR:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // SRAM pins are Moore-decoded so no input can glitch them
    always_comb begin
        in_if.in_ready = 1'b0;
        sram_cen       = 1'b1;
        sram_wen       = 1'b1;
        sram_a         = '0;
        sram_d         = '0;
        case (state)
            ST_IDLE: in_if.in_ready = 1'b1;
            ST_RD: begin
                sram_cen = 1'b0;
                sram_a   = addr_q;
            end
            ST_WR: begin
                sram_cen = 1'b0;
                sram_wen = 1'b0;
                sram_a   = addr_q;
                sram_d   = result;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q  <= '0;
            addr_q  <= '0;
            acc_q   <= 1'b0;
            relu_q  <= 1'b0;
            wr_done <= 1'b0;
        end else begin
            if (accept) begin
                data_q <= in_if.in_data;
                addr_q <= in_if.in_addr;
                acc_q  <= in_if.acc_mode;
                relu_q <= in_if.relu_en;
            end
            wr_done <= (state == ST_WR);
        end
    end

    for (genvar i = 0; i < int'(col); i++) begin : g_lane
        sfp_lane #(.psum_bw(psum_bw)) u_lane (
            .acc     (acc_q),
            .relu_en (relu_q),
            .a       (data_q[i*psum_bw +: psum_bw]),
            .q       (sram_q[i*psum_bw +: psum_bw]),
            .y       (result[i*psum_bw +: psum_bw])
        );
    end

endmodule

// File: tb/tb_sfp_accum.sv
// Directed-vector bench for sfp_accum with a behavioural 16x160 SRAM model.
module tb_sfp_accum;
    localparam int unsigned W  = 160;
    localparam int unsigned LW = 20;
    localparam int unsigned NV = 12;

    typedef struct {
        logic [3:0]   addr;
        logic         acc;
        logic         relu;
        logic [W-1:0] data;
        logic [W-1:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] sram_q;
    logic         sram_cen, sram_wen, wr_done;
    logic [3:0]   sram_a;
    logic [W-1:0] sram_d;
    logic [W-1:0] mem [16];
    int           wr_cnt [16];
    int           n_vec = 0;
    int           n_bad = 0;
    vec_t         tbl [NV];

    sfp_accum_if bus ();

    sfp_accum dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_if    (bus.slave),
        .sram_q   (sram_q),
        .sram_cen (sram_cen),
        .sram_wen (sram_wen),
        .sram_a   (sram_a),
        .sram_d   (sram_d),
        .wr_done  (wr_done)
    );

    always #5 clk = ~clk;

    // SRAM: Q updates only on read cycles
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) begin
                mem[sram_a]    <= sram_d;
                wr_cnt[sram_a] <= wr_cnt[sram_a] + 1;
            end else begin
                sram_q <= mem[sram_a];
            end
        end
    end

    function automatic logic [W-1:0] rep(input logic [LW-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++) r[i*LW +: LW] = v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic txn(input vec_t v, input string tag);
        @(negedge clk);
        chk({tag, " ready_idle"}, W'(bus.in_ready), W'(1'b1));
        chk({tag, " done_low"}, W'(wr_done), W'(1'b0));
        bus.in_valid = 1'b1;
        bus.in_addr  = v.addr;
        bus.acc_mode = v.acc;
        bus.relu_en  = v.relu;
        bus.in_data  = v.data;
        @(posedge clk);
        #1;
        // Scrambled inputs after acceptance must be ignored
        bus.in_valid = 1'b0;
        bus.in_addr  = ~v.addr;
        bus.acc_mode = ~v.acc;
        bus.in_data  = ~v.data;
        if (v.acc) begin
            @(negedge clk);
            chk({tag, " rd_pins"}, W'({sram_cen, sram_wen, bus.in_ready}), W'(3'b010));
            chk({tag, " rd_addr"}, W'(sram_a), W'(v.addr));
        end
        @(negedge clk);
        chk({tag, " wr_pins"}, W'({sram_cen, sram_wen, bus.in_ready}), W'(3'b000));
        chk({tag, " wr_addr"}, W'(sram_a), W'(v.addr));
        chk({tag, " wr_data"}, sram_d, v.exp);
        @(negedge clk);
        chk({tag, " done"}, W'({wr_done, bus.in_ready, sram_cen}), W'(3'b111));
        chk({tag, " d_idle"}, sram_d, '0);
        chk({tag, " readback"}, mem[v.addr], v.exp);
    endtask

    initial begin
        int   acc_cyc [4];
        int   k;
        int   cyc;
        int   wc0;
        logic rdy;
        vec_t v;

        // Directed vectors: chained so each accumulate reads the prior write
        tbl[0]  = '{4'd3, 1'b0, 1'b0, rep(20'd5), rep(20'd5)};
        tbl[1]  = '{4'd3, 1'b1, 1'b0, rep(20'hFFFF9), rep(20'hFFFFE)};
        tbl[2]  = '{4'd5, 1'b0, 1'b0, rep(20'h7FFF0), rep(20'h7FFF0)};
        tbl[3]  = '{4'd5, 1'b1, 1'b0, rep(20'h00100), rep(20'h7FFFF)};
        tbl[4]  = '{4'd6, 1'b0, 1'b0, rep(20'h80000), rep(20'h80000)};
        tbl[5]  = '{4'd6, 1'b1, 1'b0, rep(20'hFFFFF), rep(20'h80000)};
        tbl[6]  = '{4'd7, 1'b0, 1'b0, rep(20'hFFFFE), rep(20'hFFFFE)};
`ifdef SFP_RELU_EN
        tbl[7]  = '{4'd7, 1'b1, 1'b1, rep(20'd1), rep(20'd0)};
        tbl[8]  = '{4'd8, 1'b0, 1'b1, rep(20'hFFFFD), rep(20'd0)};
`else
        tbl[7]  = '{4'd7, 1'b1, 1'b1, rep(20'd1), rep(20'hFFFFF)};
        tbl[8]  = '{4'd8, 1'b0, 1'b1, rep(20'hFFFFD), rep(20'hFFFFD)};
`endif
        tbl[9]  = '{4'd10, 1'b0, 1'b1, rep(20'd4), rep(20'd4)};
        tbl[10] = '{4'd9, 1'b0, 1'b0, '0, '0};
        tbl[11] = '{4'd9, 1'b1, 1'b0, rep(20'd10), '0};
        // Distinct per-lane values catch lane ordering errors
        for (int i = 0; i < 8; i++) begin
            tbl[10].data[i*LW +: LW] = LW'(i * 1000 - 3000);
            tbl[10].exp[i*LW +: LW]  = LW'(i * 1000 - 3000);
            tbl[11].exp[i*LW +: LW]  = LW'(i * 1000 - 2990);
        end

        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_addr  = '0;
        bus.acc_mode = 1'b0;
        bus.relu_en  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset pins", W'({sram_cen, sram_wen, bus.in_ready, wr_done}), W'(4'b1110));
        chk("reset addr", W'(sram_a), '0);
        chk("reset data", sram_d, '0);
        reset_n = 1'b1;

        for (int i = 0; i < int'(NV); i++) begin
            txn(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-to-back accumulates to one address with in_valid held high
        txn('{4'd12, 1'b0, 1'b0, rep(20'd1), rep(20'd1)}, "bp_init");
        wc0 = wr_cnt[12];
        k   = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_addr  = 4'd12;
            bus.acc_mode = 1'b1;
            bus.relu_en  = 1'b0;
            bus.in_data  = rep(LW'(k + 1));
            rdy = bus.in_ready;
            @(posedge clk);
            if (rdy) begin
                acc_cyc[k] = cyc;
                k++;
            end
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp accepted", W'(k), W'(4));
        for (int j = 1; j < 4; j++) begin
            if (j < k) chk($sformatf("bp gap%0d", j), W'(acc_cyc[j] - acc_cyc[j-1]), W'(3));
        end
        repeat (4) @(negedge clk);
        chk("bp sum", mem[12], rep(20'd11));
        chk("bp writes", W'(wr_cnt[12] - wc0), W'(4));

        // Reset during RD must abort without a write
        txn('{4'd13, 1'b0, 1'b0, rep(20'd9), rep(20'd9)}, "rst_init");
        wc0 = wr_cnt[13];
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_addr  = 4'd13;
        bus.acc_mode = 1'b1;
        bus.in_data  = rep(20'd100);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst in_rd", W'({sram_cen, sram_wen}), W'(2'b01));
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst pins", W'({sram_cen, sram_wen, bus.in_ready, wr_done}), W'(4'b1110));
        chk("rst addr", W'(sram_a), '0);
        chk("rst data", sram_d, '0);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst no_done", W'(wr_done), W'(1'b0));
        end
        chk("rst entry", mem[13], rep(20'd9));
        chk("rst writes", W'(wr_cnt[13] - wc0), W'(0));

        // Normal operation resumes after the abort
        v = '{4'd13, 1'b1, 1'b0, rep(20'd100), rep(20'd109)};
        txn(v, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
